regfile_writeback_queue: RTL

// Write-back stage feeding the 8x8 register array. Accepts results from the ALU and memory

---
 rtl/regfile_writeback_queue_if.sv | 37 +++
 rtl/regfile_writeback_queue.sv | 101 ++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue_if.sv
// Handshake and register-file strobe bundle between the result producers,
// the write-back queue and the register array.
interface regfile_writeback_queue_if #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8
);
    localparam int DEST_W = $clog2(NREGS);

    logic              mem_valid;
    logic              mem_ready;
    logic [DEST_W-1:0] mem_dest;
    logic [DATA_W-1:0] mem_data;
    logic              alu_valid;
    logic              alu_ready;
    logic [DEST_W-1:0] alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic              wb_hold;
    logic [NREGS-1:0]  write_enable;
    logic [DATA_W-1:0] data_in;
    logic [NREGS-1:0]  pending;

    modport master (
        output mem_valid, mem_dest, mem_data,
        output alu_valid, alu_dest, alu_data,
        output wb_hold,
        input  mem_ready, alu_ready,
        input  write_enable, data_in, pending
    );

    modport slave (
        input  mem_valid, mem_dest, mem_data,
        input  alu_valid, alu_dest, alu_data,
        input  wb_hold,
        output mem_ready, alu_ready,
        output write_enable, data_in, pending
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order write-back FIFO merging memory and ALU results (memory has priority),
// draining one registered one-hot register write per cycle with a hazard mask.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int NREGS  = 8
) (
    input  logic clk,
    input  logic rst,
    regfile_writeback_queue_if.slave wb
);
    localparam int AW     = $clog2(DEPTH);
    localparam int DEST_W = $clog2(NREGS);

    logic [DEST_W-1:0] dest_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW:0]       count_reg;
    logic [NREGS-1:0]  write_enable_reg;
    logic [DATA_W-1:0] data_in_reg;

    logic              deq;
    logic              space;
    logic              enq_mem;
    logic              enq_alu;
    logic              enq;
    logic [DEST_W-1:0] enq_dest;
    logic [DATA_W-1:0] enq_data;
    logic [AW:0]       count_next;
    logic [NREGS-1:0]  head_onehot;
    logic [NREGS-1:0]  slot_mask [DEPTH];
    logic [NREGS-1:0]  queued_mask;

    // A full queue can still accept when its head leaves on the same edge.
    assign deq   = (count_reg != '0) && !wb.wb_hold;
    assign space = (count_reg < (AW+1)'(DEPTH)) || ((count_reg == (AW+1)'(DEPTH)) && deq);

    assign wb.mem_ready = rst && space;
    assign wb.alu_ready = rst && space && !wb.mem_valid;

    assign enq_mem  = wb.mem_valid && wb.mem_ready;
    assign enq_alu  = wb.alu_valid && wb.alu_ready;
    assign enq      = enq_mem || enq_alu;
    assign enq_dest = enq_mem ? wb.mem_dest : wb.alu_dest;
    assign enq_data = enq_mem ? wb.mem_data : wb.alu_data;

    assign count_next  = count_reg + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
    assign head_onehot = (NREGS'(1) << dest_mem[rd_ptr_reg]) & ~NREGS'(1);

    // Storage needs no reset: count_reg alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            dest_mem[wr_ptr_reg] <= enq_dest;
            data_mem[wr_ptr_reg] <= enq_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
            write_enable_reg <= '0;
            data_in_reg      <= '0;
        end else begin
            count_reg <= count_next;
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (deq) begin
                rd_ptr_reg       <= rd_ptr_reg + AW'(1);
                write_enable_reg <= head_onehot;
                data_in_reg      <= data_mem[rd_ptr_reg];
            end else begin
                write_enable_reg <= '0;
            end
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [AW-1:0] offset;
            assign offset        = AW'(gi) - rd_ptr_reg;
            assign slot_mask[gi] = ({1'b0, offset} < count_reg) ? (NREGS'(1) << dest_mem[gi]) : '0;
        end
    endgenerate

    always_comb begin
        queued_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            queued_mask = queued_mask | slot_mask[i];
        end
    end

    assign wb.pending      = (queued_mask | write_enable_reg) & ~NREGS'(1);
    assign wb.write_enable = write_enable_reg;
    assign wb.data_in      = data_in_reg;
endmodule
